// File: rtl/avalon_rcn_arb.sv
`default_nettype none
// ==========================================================================
// avalon_rcn_arb : 4-port Avalon-MM round-robin arbiter with in-order read tags
// Build option AVALON_RCN_ARB_PRIORITY_EN: fixed priority, requester 0 highest
// Revision: 1.0
// ==========================================================================
module avalon_rcn_arb #(
  parameter int RD_DEPTH = 8
) (
  input  logic         av_clk,
  input  logic         av_rst_n,
  output logic [3:0]   m_waitrequest,
  input  logic [87:0]  m_address,
  input  logic [3:0]   m_write,
  input  logic [3:0]   m_read,
  input  logic [15:0]  m_byteenable,
  input  logic [127:0] m_writedata,
  output logic [31:0]  m_readdata,
  output logic [3:0]   m_readdatavalid,
  input  logic         s_waitrequest,
  output logic [21:0]  s_address,
  output logic         s_write,
  output logic         s_read,
  output logic [3:0]   s_byteenable,
  output logic [31:0]  s_writedata,
  input  logic [31:0]  s_readdata,
  input  logic         s_readdatavalid,
  output logic         rd_orphan
);

  localparam int AW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(RD_DEPTH);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]    mem_q [RD_DEPTH];
  logic [1:0]    mem_d [RD_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_orphan_q, rd_orphan_d;

  logic [21:0] addr_a [4];
  logic [3:0]  be_a   [4];
  logic [31:0] wd_a   [4];
  logic [3:0]  pending;
  logic [1:0]  rr_next;
  logic [2:0]  pick_idle, pick_acc;
  logic        fifo_full, fifo_empty, rd_only, accept, push, pop;

  for (genvar i = 0; i < 4; i++) begin : g_unpack
    assign addr_a[i] = m_address[22*i +: 22];
    assign be_a[i]   = m_byteenable[4*i +: 4];
    assign wd_a[i]   = m_writedata[32*i +: 32];
  end

  // Returns {found, index} of the first request at or after base, modulo 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + k[1:0];
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef AVALON_RCN_ARB_PRIORITY_EN
  assign rr_next = 2'd0;
`else
  assign rr_next = gnt_q + 2'd1;
`endif

  assign pending    = m_read | m_write;
  assign rd_only    = m_read[gnt_q] & ~m_write[gnt_q];
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign accept     = (s_read | s_write) & ~s_waitrequest;
  assign push       = accept & s_read;
  assign pop        = s_readdatavalid & ~fifo_empty;
  assign pick_idle  = rr_pick(pending, rr_ptr_q);
  assign pick_acc   = rr_pick(pending, rr_next);
  assign rd_orphan  = rd_orphan_q;
  assign m_readdata = s_readdata;

  always_ff @(posedge av_clk or negedge av_rst_n) begin
    if (!av_rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'd0;
      rr_ptr_q    <= 2'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_orphan_q <= 1'b0;
      for (int i = 0; i < RD_DEPTH; i++) mem_q[i] <= 2'd0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_orphan_q <= rd_orphan_d;
      mem_q       <= mem_d;
    end
  end

  // Grant select sees only the strobes; s_waitrequest only qualifies acceptance.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (pick_idle[2]) begin
          gnt_d   = pick_idle[1:0];
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (accept) begin
          rr_ptr_d = rr_next;
          if (pick_acc[2]) gnt_d = pick_acc[1:0];
          else             state_d = S_IDLE;
        end else if (!pending[gnt_q]) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    s_address     = addr_a[gnt_q];
    s_byteenable  = be_a[gnt_q];
    s_writedata   = wd_a[gnt_q];
    s_write       = 1'b0;
    s_read        = 1'b0;
    m_waitrequest = 4'hF;
    if (state_q == S_BUSY) begin
      s_write              = m_write[gnt_q];
      s_read               = rd_only & ~fifo_full;
      m_waitrequest[gnt_q] = s_waitrequest | (rd_only & fifo_full);
    end
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_orphan_d = rd_orphan_q | (s_readdatavalid & fifo_empty);
    if (push) begin
      mem_d[wr_ptr_q] = gnt_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    m_readdatavalid = 4'b0000;
    if (pop) m_readdatavalid = 4'b0001 << mem_q[rd_ptr_q];
  end

endmodule
`default_nettype wire
